// File: rtl/rx_arbiter_rr.sv
// rx_arbiter_rr: merges PORT_COUNT two-phase request/acknowledge channels into a single
// FIFO write stream at one item per clock, with round-robin or fixed-priority arbitration.
module rx_arbiter_rr #(
    parameter int ID         = -1,
    parameter int SIZE       = 8,
    parameter int PORT_COUNT = 5,
    parameter int PORT_BITS  = 4,
    parameter int ARB_MODE   = 0,
    parameter int COUNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORT_COUNT-1:0]      push_req,
    input  logic [SIZE*PORT_COUNT-1:0] push_data,
    output logic [PORT_COUNT-1:0]      push_ack,
    input  logic                       fifo_full,
    output logic                       fifo_write,
    output logic [SIZE-1:0]            fifo_item_in,
    output logic [PORT_BITS-1:0]       grant_port,
    output logic [COUNT_BITS-1:0]      rx_count
);

    if ((1 << PORT_BITS) < PORT_COUNT || PORT_COUNT < 1 || PORT_COUNT > 16) begin : g_bad_cfg
        $error("rx_arbiter_rr ID %0d: PORT_COUNT must be 1..16 and fit in PORT_BITS", ID);
    end

    logic [PORT_COUNT-1:0] req_seen_q, req_seen_d;
    logic [PORT_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  fifo_write_q, fifo_write_d;
    logic [SIZE-1:0]       item_q, item_d;
    logic [PORT_BITS-1:0]  grant_q, grant_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic [PORT_COUNT-1:0] pending;
    logic                  hi_found, lo_found, accept;
    logic [PORT_BITS-1:0]  hi_idx, lo_idx, win_idx;
    logic [SIZE-1:0]       hi_item, lo_item, win_item;

    assign pending = push_req ^ req_seen_q;

    // Two searches: first pending at/above the pointer, and first pending overall;
    // the second covers the wrap back to index 0.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_item  = '0;
        lo_item  = '0;
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
            if (pending[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PORT_BITS'(i);
                lo_item  = push_data[SIZE*i +: SIZE];
            end
            if (pending[i] && !hi_found && (PORT_BITS'(i) >= rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = PORT_BITS'(i);
                hi_item  = push_data[SIZE*i +: SIZE];
            end
        end
        win_idx  = hi_found ? hi_idx : lo_idx;
        win_item = hi_found ? hi_item : lo_item;
        accept   = lo_found && !fifo_full;
    end

    always_comb begin
        req_seen_d   = req_seen_q;
        rr_ptr_d     = rr_ptr_q;
        fifo_write_d = 1'b0;
        item_d       = item_q;
        grant_d      = grant_q;
        count_d      = count_q;
        if (accept) begin
            req_seen_d   = req_seen_q ^ (PORT_COUNT'(1) << win_idx);
            fifo_write_d = 1'b1;
            item_d       = win_item;
            grant_d      = win_idx;
            count_d      = count_q + COUNT_BITS'(1);
            if (ARB_MODE == 0) begin
                rr_ptr_d = (win_idx == PORT_BITS'(PORT_COUNT - 1)) ? '0 : win_idx + PORT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_seen_q   <= '0;
            rr_ptr_q     <= '0;
            fifo_write_q <= 1'b0;
            item_q       <= '0;
            grant_q      <= '0;
            count_q      <= '0;
        end else begin
            req_seen_q   <= req_seen_d;
            rr_ptr_q     <= rr_ptr_d;
            fifo_write_q <= fifo_write_d;
            item_q       <= item_d;
            grant_q      <= grant_d;
            count_q      <= count_d;
        end
    end

    // Every acceptance toggles both the ack and the seen bit, so they are the same register.
    assign push_ack     = req_seen_q;
    assign fifo_write   = fifo_write_q;
    assign fifo_item_in = item_q;
    assign grant_port   = grant_q;
    assign rx_count     = count_q;

endmodule

// File: tb/tb_rx_arbiter_rr.sv
// Directed bench for rx_arbiter_rr: a round-robin instance (4-bit counter) and a
// fixed-priority instance sharing clock, reset, fifo_full and data.
module tb_rx_arbiter_rr;

    logic        clk;
    logic        reset;
    logic        fifo_full;
    logic [39:0] push_data;
    logic [4:0]  req_rr, req_fp, ack_rr, ack_fp;
    logic        fw_rr, fw_fp;
    logic [7:0]  item_rr, item_fp;
    logic [3:0]  gp_rr, gp_fp;
    logic [3:0]  cnt_rr;
    logic [15:0] cnt_fp;

    int n_checks = 0;
    int n_fail   = 0;

    rx_arbiter_rr #(.ID(0), .SIZE(8), .PORT_COUNT(5), .PORT_BITS(4), .ARB_MODE(0), .COUNT_BITS(4)) dut_rr (
        .clk(clk), .reset(reset), .push_req(req_rr), .push_data(push_data), .push_ack(ack_rr),
        .fifo_full(fifo_full), .fifo_write(fw_rr), .fifo_item_in(item_rr), .grant_port(gp_rr),
        .rx_count(cnt_rr)
    );

    rx_arbiter_rr #(.ID(1), .SIZE(8), .PORT_COUNT(5), .PORT_BITS(4), .ARB_MODE(1), .COUNT_BITS(16)) dut_fp (
        .clk(clk), .reset(reset), .push_req(req_fp), .push_data(push_data), .push_ack(ack_fp),
        .fifo_full(fifo_full), .fifo_write(fw_fp), .fifo_item_in(item_fp), .grant_port(gp_fp),
        .rx_count(cnt_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (fw_rr) $display("accept t=%0t id=0 item=%h port=%0d", $time, item_rr, gp_rr);
        if (fw_fp) $display("accept t=%0t id=1 item=%h port=%0d", $time, item_fp, gp_fp);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        push_data[k*8 +: 8] = v;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({ack_rr, fw_rr, item_rr, gp_rr, cnt_rr} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_rr: got %h expected 0", {ack_rr, fw_rr, item_rr, gp_rr, cnt_rr});
        end
        n_checks++;
        if ({ack_fp, fw_fp, item_fp, gp_fp, cnt_fp} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_fp: got %h expected 0", {ack_fp, fw_fp, item_fp, gp_fp, cnt_fp});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({fw_rr, cnt_rr, fw_fp} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0", {fw_rr, cnt_rr, fw_fp});
        end
    endtask

    task automatic test_single_item();
        set_data(2, 8'hA5);
        req_rr[2] = 1'b1;
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr, ack_rr} !== {1'b1, 8'hA5, 4'd2, 4'd1, 5'b00100}) begin
            n_fail++;
            $display("FAIL single_accept: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr, ack_rr},
                     {1'b1, 8'hA5, 4'd2, 4'd1, 5'b00100});
        end
        tick();
        n_checks++;
        if ({fw_rr, ack_rr, cnt_rr} !== {1'b0, 5'b00100, 4'd1}) begin
            n_fail++;
            $display("FAIL single_idle: got %h expected %h", {fw_rr, ack_rr, cnt_rr}, {1'b0, 5'b00100, 4'd1});
        end
        // port 4 moves the pointer through its wrap back to 0
        set_data(4, 8'h3C);
        req_rr[4] = 1'b1;
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr, ack_rr} !== {1'b1, 8'h3C, 4'd4, 4'd2, 5'b10100}) begin
            n_fail++;
            $display("FAIL single_port4: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr, ack_rr},
                     {1'b1, 8'h3C, 4'd4, 4'd2, 5'b10100});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gp[5];
        logic [3:0] exp_cnt[5];
        exp_gp  = '{4'd0, 4'd1, 4'd4, 4'd1, 4'd0};
        exp_cnt = '{4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
        set_data(0, 8'h10);
        set_data(1, 8'h11);
        set_data(4, 8'h14);
        req_rr = req_rr ^ 5'b10011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({fw_rr, gp_rr, cnt_rr} !== {1'b1, exp_gp[i], exp_cnt[i]}) begin
                n_fail++;
                $display("FAIL rr_burst[%0d]: got %h expected %h", i, {fw_rr, gp_rr, cnt_rr},
                         {1'b1, exp_gp[i], exp_cnt[i]});
            end
        end
        req_rr[0] = ~req_rr[0];
        tick();
        n_checks++;
        if ({fw_rr, gp_rr, cnt_rr} !== {1'b1, 4'd0, 4'd6}) begin
            n_fail++;
            $display("FAIL rr_port0: got %h expected %h", {fw_rr, gp_rr, cnt_rr}, {1'b1, 4'd0, 4'd6});
        end
        // pointer now at 1, so port 1 must win over port 0
        req_rr = req_rr ^ 5'b00011;
        for (int i = 3; i < 5; i++) begin
            tick();
            n_checks++;
            if ({fw_rr, gp_rr, cnt_rr} !== {1'b1, exp_gp[i], exp_cnt[i]}) begin
                n_fail++;
                $display("FAIL rr_rotate[%0d]: got %h expected %h", i, {fw_rr, gp_rr, cnt_rr},
                         {1'b1, exp_gp[i], exp_cnt[i]});
            end
        end
        tick();
        n_checks++;
        if ({fw_rr, ack_rr} !== {1'b0, 5'b00101}) begin
            n_fail++;
            $display("FAIL rr_drained: got %h expected %h", {fw_rr, ack_rr}, {1'b0, 5'b00101});
        end
    endtask

    task automatic test_backpressure();
        fifo_full = 1'b1;
        set_data(0, 8'h50);
        set_data(2, 8'h52);
        req_rr = req_rr ^ 5'b00101;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({fw_rr, ack_rr, cnt_rr} !== {1'b0, 5'b00101, 4'd8}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i, {fw_rr, ack_rr, cnt_rr},
                         {1'b0, 5'b00101, 4'd8});
            end
        end
        fifo_full = 1'b0;
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr} !== {1'b1, 8'h52, 4'd2, 4'd9}) begin
            n_fail++;
            $display("FAIL bp_first: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr},
                     {1'b1, 8'h52, 4'd2, 4'd9});
        end
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr, ack_rr} !== {1'b1, 8'h50, 4'd0, 4'd10, 5'b00000}) begin
            n_fail++;
            $display("FAIL bp_second: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr, ack_rr},
                     {1'b1, 8'h50, 4'd0, 4'd10, 5'b00000});
        end
    endtask

    task automatic test_fixed_priority();
        set_data(1, 8'h21);
        set_data(3, 8'h23);
        req_fp = req_fp ^ 5'b01010;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({fw_fp, item_fp, gp_fp, cnt_fp} !== {1'b1, 8'h21 + 8'(i), 4'd1, 16'(i + 1)}) begin
                n_fail++;
                $display("FAIL fp_port1[%0d]: got %h expected %h", i, {fw_fp, item_fp, gp_fp, cnt_fp},
                         {1'b1, 8'h21 + 8'(i), 4'd1, 16'(i + 1)});
            end
            if (i < 2) begin
                req_fp[1] = ~req_fp[1];
                set_data(1, 8'h22 + 8'(i));
            end
        end
        tick();
        n_checks++;
        if ({fw_fp, item_fp, gp_fp, cnt_fp} !== {1'b1, 8'h23, 4'd3, 16'd4}) begin
            n_fail++;
            $display("FAIL fp_port3: got %h expected %h", {fw_fp, item_fp, gp_fp, cnt_fp},
                     {1'b1, 8'h23, 4'd3, 16'd4});
        end
        req_fp[0] = ~req_fp[0];
        fifo_full = 1'b1;
        tick();
        n_checks++;
        if ({fw_fp, ack_fp, cnt_fp} !== {1'b0, 5'b01010, 16'd4}) begin
            n_fail++;
            $display("FAIL fp_full_edge: got %h expected %h", {fw_fp, ack_fp, cnt_fp}, {1'b0, 5'b01010, 16'd4});
        end
        fifo_full = 1'b0;
        tick();
        n_checks++;
        if ({fw_fp, gp_fp, cnt_fp, ack_fp} !== {1'b1, 4'd0, 16'd5, 5'b01011}) begin
            n_fail++;
            $display("FAIL fp_release: got %h expected %h", {fw_fp, gp_fp, cnt_fp, ack_fp},
                     {1'b1, 4'd0, 16'd5, 5'b01011});
        end
    endtask

    task automatic test_counter_wrap();
        req_rr = '0;
        req_fp = '0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            req_rr[3] = ~req_rr[3];
            set_data(3, 8'h40 + 8'(i));
            tick();
            n_checks++;
            if ({fw_rr, item_rr, gp_rr, cnt_rr} !== {1'b1, 8'h40 + 8'(i), 4'd3, 4'((i + 1) % 16)}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, {fw_rr, item_rr, gp_rr, cnt_rr},
                         {1'b1, 8'h40 + 8'(i), 4'd3, 4'((i + 1) % 16)});
            end
        end
        n_checks++;
        if (cnt_rr !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_final: got %0d expected 1", cnt_rr);
        end
    endtask

    task automatic test_mid_reset();
        set_data(0, 8'h60);
        set_data(3, 8'h63);
        req_rr[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ack_rr, fw_rr, item_rr, gp_rr, cnt_rr} !== 22'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h expected 0", {ack_rr, fw_rr, item_rr, gp_rr, cnt_rr});
        end
        tick();
        n_checks++;
        if ({ack_rr, fw_rr, cnt_rr} !== 10'h0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %h expected 0", {ack_rr, fw_rr, cnt_rr});
        end
        #3;
        reset = 1'b0;
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr, ack_rr} !== {1'b1, 8'h60, 4'd0, 4'd1, 5'b00001}) begin
            n_fail++;
            $display("FAIL mid_reset_first: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr, ack_rr},
                     {1'b1, 8'h60, 4'd0, 4'd1, 5'b00001});
        end
        tick();
        n_checks++;
        if ({fw_rr, item_rr, gp_rr, cnt_rr, ack_rr} !== {1'b1, 8'h63, 4'd3, 4'd2, 5'b01001}) begin
            n_fail++;
            $display("FAIL mid_reset_second: got %h expected %h", {fw_rr, item_rr, gp_rr, cnt_rr, ack_rr},
                     {1'b1, 8'h63, 4'd3, 4'd2, 5'b01001});
        end
        tick();
        n_checks++;
        if (fw_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got %b expected 0", fw_rr);
        end
    endtask

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        push_data = '0;
        req_rr    = '0;
        req_fp    = '0;
        test_reset();
        test_single_item();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_counter_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
